// File: rtl/pass_engine.sv
// Datapath responder for the training-pass controller: steps forward/backward passes
// over N_ELEM elements, accumulates absolute-error loss and decides end of training.
module pass_engine #(
  parameter int DATA_W    = 8,
  parameter int LOSS_W    = 12,
  parameter int N_ELEM    = 4,
  parameter int ADDR_W    = 2,
  parameter int EPOCH_W   = 4,
  parameter int MAX_EPOCH = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     f0_pass_i,
  input  logic                     f1_pass_i,
  input  logic                     b_pass_i,
  input  logic                     zero_loss_i,
  input  logic                     zero_final_i,
  input  logic                     zero_weight_update_i,
  input  logic signed [DATA_W-1:0] err_i,
  input  logic                     err_valid_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     fwd_active_o,
  output logic                     bwd_active_o,
  output logic                     f_end_o,
  output logic                     b_end_o,
  output logic                     zero_end_check_o,
  output logic [LOSS_W-1:0]        loss_o,
  output logic [EPOCH_W-1:0]       epoch_o,
  output logic [7:0]               upd_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_CHECK, S_BWD, S_HOLD} state_e;
  localparam logic [1:0] SRV_F0 = 2'd0;
  localparam logic [1:0] SRV_F1 = 2'd1;
  localparam logic [1:0] SRV_B  = 2'd2;

  state_e              state_q, state_d;
  logic [1:0]          served_q, served_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [LOSS_W-1:0]   loss_out_q, loss_out_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [7:0]          upd_q, upd_d;
  logic                f_end_q, f_end_d;
  logic                b_end_q, b_end_d;
  logic                zec_q, zec_d;
  logic                fwd_act_q, fwd_act_d;
  logic                bwd_act_q, bwd_act_d;

  logic                served_lvl;
  logic                last_elem;
  logic [DATA_W-1:0]   abs_err;
  logic [LOSS_W:0]     loss_sum;
  logic [LOSS_W-1:0]   loss_sat;

  always_comb begin
    case (served_q)
      SRV_B:   served_lvl = b_pass_i;
      SRV_F1:  served_lvl = f1_pass_i;
      default: served_lvl = f0_pass_i;
    endcase
  end

  assign last_elem = (addr_q == ADDR_W'(N_ELEM - 1));
  // Most-negative sample wraps to 2**(DATA_W-1), which is correct as unsigned.
  assign abs_err   = err_i[DATA_W-1] ? $unsigned(-err_i) : $unsigned(err_i);
  assign loss_sum  = {1'b0, loss_q} + {{(LOSS_W + 1 - DATA_W){1'b0}}, abs_err};
  assign loss_sat  = loss_sum[LOSS_W] ? {LOSS_W{1'b1}} : loss_sum[LOSS_W-1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        S_IDLE: begin
          if (b_pass_i)                    state_d = S_BWD;
          else if (f1_pass_i || f0_pass_i) state_d = S_FWD;
        end
        S_FWD: begin
          if (!served_lvl)                    state_d = S_IDLE;
          else if (err_valid_i && last_elem)  state_d = S_CHECK;
        end
        S_CHECK: state_d = S_HOLD;
        S_BWD: begin
          if (!served_lvl)    state_d = S_IDLE;
          else if (last_elem) state_d = S_HOLD;
        end
        S_HOLD: if (!served_lvl) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    served_d   = served_q;
    addr_d     = addr_q;
    loss_d     = loss_q;
    loss_out_d = loss_out_q;
    epoch_d    = epoch_q;
    upd_d      = upd_q;
    f_end_d    = f_end_q;
    b_end_d    = b_end_q;
    zec_d      = zec_q;
    if (en_i) begin
      f_end_d = 1'b0;
      b_end_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          addr_d = '0;
          if (b_pass_i)       served_d = SRV_B;
          else if (f1_pass_i) served_d = SRV_F1;
          else if (f0_pass_i) served_d = SRV_F0;
        end
        S_FWD: begin
          if (!served_lvl) begin
            addr_d = '0;
          end else if (err_valid_i) begin
            loss_d = loss_sat;
            addr_d = last_elem ? '0 : addr_q + 1'b1;
          end
        end
        S_CHECK: begin
          loss_out_d = loss_q;
          if (served_q == SRV_F1 && (loss_q == '0 || epoch_q == EPOCH_W'(MAX_EPOCH)))
            zec_d = 1'b1;
          else
            f_end_d = 1'b1;
        end
        S_BWD: begin
          if (!served_lvl) begin
            addr_d = '0;
          end else begin
            upd_d = (upd_q == 8'hFF) ? upd_q : upd_q + 8'd1;
            if (last_elem) begin
              addr_d  = '0;
              b_end_d = 1'b1;
              epoch_d = (epoch_q == EPOCH_W'(MAX_EPOCH)) ? epoch_q : epoch_q + 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
        S_HOLD: if (!served_lvl) zec_d = 1'b0;
        default: ;
      endcase
    end
    // Clear strobes override everything, independent of en_i.
    if (zero_loss_i)          loss_d     = '0;
    if (zero_final_i)         loss_out_d = '0;
    if (zero_weight_update_i) upd_d      = '0;
    fwd_act_d = (state_d == S_FWD);
    bwd_act_d = (state_d == S_BWD);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      served_q   <= SRV_F0;
      addr_q     <= '0;
      loss_q     <= '0;
      loss_out_q <= '0;
      epoch_q    <= '0;
      upd_q      <= '0;
      f_end_q    <= 1'b0;
      b_end_q    <= 1'b0;
      zec_q      <= 1'b0;
      fwd_act_q  <= 1'b0;
      bwd_act_q  <= 1'b0;
    end else begin
      served_q   <= served_d;
      addr_q     <= addr_d;
      loss_q     <= loss_d;
      loss_out_q <= loss_out_d;
      epoch_q    <= epoch_d;
      upd_q      <= upd_d;
      f_end_q    <= f_end_d;
      b_end_q    <= b_end_d;
      zec_q      <= zec_d;
      fwd_act_q  <= fwd_act_d;
      bwd_act_q  <= bwd_act_d;
    end
  end

  assign addr_o           = addr_q;
  assign fwd_active_o     = fwd_act_q;
  assign bwd_active_o     = bwd_act_q;
  assign f_end_o          = f_end_q;
  assign b_end_o          = b_end_q;
  assign zero_end_check_o = zec_q;
  assign loss_o           = loss_out_q;
  assign epoch_o          = epoch_q;
  assign upd_cnt_o        = upd_q;

endmodule

// File: tb/tb_pass_engine.sv
// Bench for pass_engine: driver tasks issue passes, a reference model predicts end events
// into a queue, and a negedge monitor pops and compares whenever an end event appears.
module tb_pass_engine;
  localparam int DATA_W    = 8;
  localparam int LOSS_W    = 12;
  localparam int N_ELEM    = 4;
  localparam int ADDR_W    = 2;
  localparam int EPOCH_W   = 4;
  localparam int MAX_EPOCH = 2;
  localparam int REC_W     = 2 + LOSS_W + EPOCH_W + 8;
  localparam int LOSS_MAX  = (1 << LOSS_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i, en_i, f0_pass_i, f1_pass_i, b_pass_i;
  logic zero_loss_i, zero_final_i, zero_weight_update_i, err_valid_i;
  logic signed [DATA_W-1:0] err_i;
  logic [ADDR_W-1:0]  addr_o;
  logic fwd_active_o, bwd_active_o, f_end_o, b_end_o, zero_end_check_o;
  logic [LOSS_W-1:0]  loss_o;
  logic [EPOCH_W-1:0] epoch_o;
  logic [7:0]         upd_cnt_o;

  pass_engine #(.DATA_W(DATA_W), .LOSS_W(LOSS_W), .N_ELEM(N_ELEM), .ADDR_W(ADDR_W),
                .EPOCH_W(EPOCH_W), .MAX_EPOCH(MAX_EPOCH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .f0_pass_i(f0_pass_i), .f1_pass_i(f1_pass_i), .b_pass_i(b_pass_i),
    .zero_loss_i(zero_loss_i), .zero_final_i(zero_final_i),
    .zero_weight_update_i(zero_weight_update_i),
    .err_i(err_i), .err_valid_i(err_valid_i),
    .addr_o(addr_o), .fwd_active_o(fwd_active_o), .bwd_active_o(bwd_active_o),
    .f_end_o(f_end_o), .b_end_o(b_end_o), .zero_end_check_o(zero_end_check_o),
    .loss_o(loss_o), .epoch_o(epoch_o), .upd_cnt_o(upd_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [REC_W-1:0] exp_q[$];

  // reference model: end-of-pass observables in plain integers
  int m_loss, m_loss_out, m_epoch, m_upd;
  int pass_errs[N_ELEM];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input int kind);
    return {2'(kind), LOSS_W'(m_loss_out), EPOCH_W'(m_epoch), 8'(m_upd)};
  endfunction

  // monitor: 1 = f_end, 2 = b_end, 3 = zero_end_check rising
  logic zec_prev = 1'b0;
  always @(negedge clk_i) begin
    int kind;
    logic [REC_W-1:0] act, exp;
    if (!rst_i) begin
      zec_prev = 1'b0;
    end else begin
      kind = f_end_o ? 1 : b_end_o ? 2 : (zero_end_check_o && !zec_prev) ? 3 : 0;
      if (kind != 0) begin
        act = {2'(kind), loss_o, epoch_o, upd_cnt_o};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got kind=%0d rec=%h expected none", kind, act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            bad++;
            $display("FAIL end_event: got %h expected %h (kind/loss/epoch/upd)", act, exp);
          end
        end
      end
      zec_prev = zero_end_check_o;
    end
  end

  task automatic add_loss(input int e);
    int a;
    a = (e < 0) ? -e : e;
    m_loss = (m_loss + a > LOSS_MAX) ? LOSS_MAX : m_loss + a;
  endtask

  task automatic pulse_zero_loss();
    zero_loss_i = 1'b1; tick(); zero_loss_i = 1'b0;
    m_loss = 0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_addr"}, int'(addr_o), 0);
    chk({nm, "_act"}, int'({fwd_active_o, bwd_active_o, f_end_o, b_end_o, zero_end_check_o}), 0);
    chk({nm, "_loss"}, int'(loss_o), 0);
    chk({nm, "_epoch"}, int'(epoch_o), 0);
    chk({nm, "_upd"}, int'(upd_cnt_o), 0);
  endtask

  task automatic fwd_pass(input bit is_f1, input int stall_at, input int zl_at, input bit also_f0);
    int gaps, extra;
    bit zend;
    if (is_f1) begin f1_pass_i = 1'b1; f0_pass_i = also_f0; end
    else f0_pass_i = 1'b1;
    tick();
    chk("fwd_active", int'(fwd_active_o), 1);
    for (int i = 0; i < N_ELEM; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        err_valid_i = 1'b0; err_i = DATA_W'($urandom); tick();
      end
      if (i == stall_at) begin
        en_i = 1'b0; err_valid_i = 1'b1; err_i = DATA_W'($urandom);
        repeat (3) tick();
        chk("stall_addr", int'(addr_o), i);
        chk("stall_active", int'(fwd_active_o), 1);
        en_i = 1'b1;
      end
      chk("fwd_addr", int'(addr_o), i);
      err_i = DATA_W'(pass_errs[i]); err_valid_i = 1'b1;
      zero_loss_i = (i == zl_at);
      if (i == zl_at) m_loss = 0;
      else add_loss(pass_errs[i]);
      tick();
      zero_loss_i = 1'b0;
    end
    err_valid_i = 1'b0;
    chk("check_addr", int'(addr_o), 0);
    zend = is_f1 && (m_loss == 0 || m_epoch == MAX_EPOCH);
    m_loss_out = m_loss;
    exp_q.push_back(mk_rec(zend ? 3 : 1));
    tick();
    extra = $urandom_range(0, 2);
    repeat (extra) tick();
    chk("zec_hold", int'(zero_end_check_o), int'(zend));
    f0_pass_i = 1'b0; f1_pass_i = 1'b0;
    tick();
    chk("zec_idle", int'(zero_end_check_o), 0);
    chk("loss_snapshot", int'(loss_o), m_loss_out);
  endtask

  task automatic bwd_pass();
    b_pass_i = 1'b1;
    tick();
    for (int i = 0; i < N_ELEM; i++) begin
      chk("bwd_active", int'(bwd_active_o), 1);
      chk("bwd_addr", int'(addr_o), i);
      if (m_upd < 255) m_upd++;
      if (i == N_ELEM - 1) begin
        if (m_epoch < MAX_EPOCH) m_epoch++;
        exp_q.push_back(mk_rec(2));
      end
      tick();
    end
    chk("bwd_hold_active", int'(bwd_active_o), 0);
    tick();
    b_pass_i = 1'b0;
    tick();
    chk("epoch", int'(epoch_o), m_epoch);
    chk("upd_cnt", int'(upd_cnt_o), m_upd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_i = 1'b0; en_i = 1'b1; f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0;
    zero_loss_i = 1'b0; zero_final_i = 1'b0; zero_weight_update_i = 1'b0;
    err_i = '0; err_valid_i = 1'b0;
    m_loss = 0; m_loss_out = 0; m_epoch = 0; m_upd = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_i = 1'b1;
    tick();

    // f0 with known samples and an enable stall
    pass_errs = '{3, -2, 0, 5};
    fwd_pass(1'b0, 1, -1, 1'b0);
    chk("first_loss", int'(loss_o), 10);

    bwd_pass();
    chk("first_epoch", int'(epoch_o), 1);
    chk("first_upd", int'(upd_cnt_o), 4);

    // f1 with zero loss ends training
    pulse_zero_loss();
    pass_errs = '{0, 0, 0, 0};
    fwd_pass(1'b1, -1, -1, 1'b1);

    // f1 with nonzero loss below epoch limit: ordinary f_end
    pulse_zero_loss();
    pass_errs = '{-7, 1, 20, -3};
    fwd_pass(1'b1, -1, -1, 1'b0);

    // reach and saturate the epoch limit, then f1 ends on epoch
    bwd_pass();
    bwd_pass();
    chk("epoch_sat", int'(epoch_o), MAX_EPOCH);
    pulse_zero_loss();
    pass_errs = '{9, -9, 4, 4};
    fwd_pass(1'b1, -1, -1, 1'b0);

    // backward abort after two steps
    b_pass_i = 1'b1; tick(); tick(); tick();
    m_upd += 2;
    b_pass_i = 1'b0; tick();
    chk("abort_addr", int'(addr_o), 0);
    chk("abort_active", int'(bwd_active_o), 0);
    chk("abort_epoch", int'(epoch_o), m_epoch);
    chk("abort_upd", int'(upd_cnt_o), m_upd);

    // clear strobes, the weight/final ones under en_i=0
    en_i = 1'b0; zero_weight_update_i = 1'b1; zero_final_i = 1'b1; tick();
    zero_weight_update_i = 1'b0; zero_final_i = 1'b0; en_i = 1'b1;
    m_upd = 0; m_loss_out = 0;
    chk("zero_upd", int'(upd_cnt_o), 0);
    chk("zero_final", int'(loss_o), 0);

    // saturation: 40 samples of the most negative value
    pulse_zero_loss();
    pass_errs = '{-128, -128, -128, -128};
    for (int p = 0; p < 10; p++) fwd_pass(1'b0, -1, -1, 1'b0);
    chk("loss_sat", int'(loss_o), LOSS_MAX);

    // zero_loss in the same cycle as an accepted sample
    pass_errs = '{11, 22, 33, 44};
    fwd_pass(1'b0, -1, 1, 1'b0);
    chk("zl_same_cycle", int'(loss_o), 77);

    // randomized passes
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 2);
      if (r == 0) bwd_pass();
      else begin
        if ($urandom_range(0, 1) == 1) pulse_zero_loss();
        for (int i = 0; i < N_ELEM; i++)
          pass_errs[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
        fwd_pass(r == 2, int'($urandom_range(0, 5)) - 1, -1, 1'($urandom_range(0, 1)));
      end
    end

    // reset in the middle of a forward pass
    pass_errs = '{5, 6, 7, 8};
    f0_pass_i = 1'b1; tick();
    err_i = 8'sd5; err_valid_i = 1'b1; tick(); tick();
    rst_i = 1'b0; #1;
    check_all_zero("mid_reset");
    f0_pass_i = 1'b0; err_valid_i = 1'b0;
    m_loss = 0; m_loss_out = 0; m_epoch = 0; m_upd = 0;
    tick(); rst_i = 1'b1; tick();
    check_all_zero("post_reset");

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
